// File: rtl/run_monitor_pkg.sv
`default_nettype none
// ============================================================================
// run_monitor_pkg : record kinds, monitor states and SUMMARY flag positions
// Revision 1.0
// ============================================================================
package run_monitor_pkg;

   localparam logic [1:0] c_KIND_TRACE   = 2'd0;
   localparam logic [1:0] c_KIND_DUMP    = 2'd1;
   localparam logic [1:0] c_KIND_SUMMARY = 2'd2;

   localparam int c_INDEX_W       = 16;
   localparam int c_FLAG_TIMEOUT  = 0;
   localparam int c_FLAG_OVERFLOW = 1;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_DUMP    = 3'd2,
      ST_SUMMARY = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/run_monitor_trace_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo : first-word-fall-through FIFO, DEPTH a power of two (>= 2)
// Revision 1.0
// ============================================================================
module trace_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == (c_AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_pop_ok  = i_pop && !o_empty;
   // At full a same-cycle pop frees the slot the push writes into.
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (c_AW+1)'(1);
            2'b01:   r_count <= r_count - (c_AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// run_monitor : cycle counter, store tracer, halt/timeout memory dump, summary
// Revision 1.0
// ============================================================================
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int unsigned       BASE_ADDR   = 8192,
   parameter int                NUM_WORDS   = 46,
   parameter logic [DATA_W-1:0] HALT_INSTR  = '1,
   parameter int unsigned       MAX_CYCLES  = 100000,
   parameter int                TRACE_DEPTH = 4,
   parameter int                CNT_W       = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_W-1:0]    inst,
   input  logic                 snoop_we,
   input  logic [DATA_W-1:0]    snoop_addr,
   input  logic [DATA_W-1:0]    snoop_data,
   output logic [DATA_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_kind,
   output logic [c_INDEX_W-1:0] out_index,
   output logic [DATA_W-1:0]    out_data,
   output logic                 done,
   output logic                 timeout,
   output logic                 overflow
);

   localparam int                c_FIFO_W      = c_INDEX_W + DATA_W;
   localparam logic [DATA_W-1:0] c_BASE        = DATA_W'(BASE_ADDR);
   localparam logic [DATA_W:0]   c_LIMIT       = (DATA_W+1)'(BASE_ADDR) + (DATA_W+1)'(4 * NUM_WORDS);
   localparam logic [c_INDEX_W-1:0] c_LAST_IDX = c_INDEX_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0]  c_TMO_CNT     = CNT_W'(MAX_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cycle_count;
   logic [DATA_W-1:0]     r_mem_addr;
   logic                  r_out_valid;
   logic [1:0]            r_out_kind;
   logic [c_INDEX_W-1:0]  r_out_index;
   logic [DATA_W-1:0]     r_out_data;
   logic                  r_done;
   logic                  r_timeout;
   logic                  r_overflow;

   logic                  w_hit;
   logic [DATA_W-1:0]     w_offset;
   logic                  w_trace_sel;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [c_FIFO_W-1:0]   w_head;
   logic                  w_halt;
   logic                  w_tmo;
   logic                  w_hs;
   logic [c_INDEX_W-1:0]  w_flags;

   assign w_hit       = snoop_we && ({1'b0, snoop_addr} >= {1'b0, c_BASE})
                                 && ({1'b0, snoop_addr} <  c_LIMIT);
   assign w_offset    = snoop_addr - c_BASE;
   assign w_trace_sel = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_push      = (r_state == ST_RUN) && w_hit;
   assign w_pop       = w_trace_sel && out_ready;
   assign w_halt      = (inst == HALT_INSTR);
   assign w_tmo       = (r_cycle_count == c_TMO_CNT);
   assign w_hs        = out_valid && out_ready;

   always_comb begin
      w_flags                  = '0;
      w_flags[c_FLAG_TIMEOUT]  = r_timeout;
      w_flags[c_FLAG_OVERFLOW] = r_overflow;
   end

   trace_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (c_FIFO_W)
   ) u_trace_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({c_INDEX_W'(w_offset >> 2), snoop_data}),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:     if (w_halt || w_tmo)                  w_state_nxt = ST_DRAIN;
         ST_DRAIN:   if (w_fifo_empty)                     w_state_nxt = ST_DUMP;
         ST_DUMP:    if (w_hs && r_out_index == c_LAST_IDX) w_state_nxt = ST_SUMMARY;
         ST_SUMMARY: if (w_hs)                             w_state_nxt = ST_DONE;
         ST_DONE:                                          w_state_nxt = ST_DONE;
         default:                                          w_state_nxt = ST_RUN;
      endcase
   end

   // mem_addr always points at the word to be captured on the next load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cycle_count <= '0;
         r_mem_addr    <= '0;
         r_out_valid   <= 1'b0;
         r_out_kind    <= '0;
         r_out_index   <= '0;
         r_out_data    <= '0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_cycle_count <= r_cycle_count + CNT_W'(1);
               if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
               if (w_halt || w_tmo)                 r_mem_addr <= c_BASE;
               if (!w_halt && w_tmo)                r_timeout  <= 1'b1;
            end
            ST_DRAIN: begin
               if (w_fifo_empty) begin
                  r_out_valid <= 1'b1;
                  r_out_kind  <= c_KIND_DUMP;
                  r_out_index <= '0;
                  r_out_data  <= mem_data;
                  r_mem_addr  <= r_mem_addr + DATA_W'(4);
               end
            end
            ST_DUMP: begin
               if (w_hs) begin
                  if (r_out_index == c_LAST_IDX) begin
                     r_out_kind  <= c_KIND_SUMMARY;
                     r_out_index <= w_flags;
                     r_out_data  <= DATA_W'(r_cycle_count);
                  end else begin
                     r_out_index <= r_out_index + c_INDEX_W'(1);
                     r_out_data  <= mem_data;
                     r_mem_addr  <= r_mem_addr + DATA_W'(4);
                  end
               end
            end
            ST_SUMMARY: begin
               if (w_hs) begin
                  r_out_valid <= 1'b0;
                  r_out_kind  <= '0;
                  r_out_index <= '0;
                  r_out_data  <= '0;
                  r_done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = w_trace_sel ? !w_fifo_empty : r_out_valid;
   assign out_kind  = w_trace_sel ? c_KIND_TRACE : r_out_kind;
   assign out_index = w_trace_sel ? (w_fifo_empty ? '0 : w_head[c_FIFO_W-1 -: c_INDEX_W]) : r_out_index;
   assign out_data  = w_trace_sel ? (w_fifo_empty ? '0 : w_head[DATA_W-1:0]) : r_out_data;
   assign mem_addr  = r_mem_addr;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// tb_run_monitor : directed cycle-exact checks of trace, dump, summary, reset
// Revision 1.0
// ============================================================================
module tb_run_monitor;
   import run_monitor_pkg::*;

   localparam int          NUM_WORDS = 4;
   localparam logic [31:0] c_HALT    = 32'hFFFF_FFFF;
   localparam logic [31:0] c_BASE    = 32'd8192;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inst = '0;
   logic        snoop_we = 1'b0;
   logic [31:0] snoop_addr = '0;
   logic [31:0] snoop_data = '0;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_kind;
   logic [15:0] out_index;
   logic [31:0] out_data;
   logic        done;
   logic        timeout;
   logic        overflow;

   logic [31:0] mem_model [NUM_WORDS];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc   = 0;

   always #5 clock = ~clock;

   always_comb begin
      mem_data = 32'hDEAD_BEEF;
      for (int i = 0; i < NUM_WORDS; i++)
         if (mem_addr == c_BASE + 32'(4 * i)) mem_data = mem_model[i];
   end

   run_monitor #(
      .DATA_W      (32),
      .BASE_ADDR   (8192),
      .NUM_WORDS   (NUM_WORDS),
      .HALT_INSTR  (32'hFFFF_FFFF),
      .MAX_CYCLES  (50),
      .TRACE_DEPTH (4),
      .CNT_W       (32)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .inst       (inst),
      .snoop_we   (snoop_we),
      .snoop_addr (snoop_addr),
      .snoop_data (snoop_data),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_kind   (out_kind),
      .out_index  (out_index),
      .out_data   (out_data),
      .done       (done),
      .timeout    (timeout),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Cycle k spans from just after edge k-1 to edge k; inputs of cycle k are taken at edge k.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic expect_rec(input string tag, input logic [1:0] kind,
                             input logic [15:0] idx, input logic [31:0] data);
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".kind"},  out_kind,  kind);
      check({tag, ".index"}, out_index, idx);
      check({tag, ".data"},  out_data,  data);
   endtask

   task automatic expect_dump(input string tag);
      for (int i = 0; i < NUM_WORDS; i++) begin
         expect_rec($sformatf("%s.dump%0d", tag, i), c_KIND_DUMP, 16'(i), mem_model[i]);
         tick();
      end
   endtask

   task automatic expect_summary(input string tag, input logic [15:0] flags, input logic [31:0] count);
      expect_rec({tag, ".sum"}, c_KIND_SUMMARY, flags, count);
      check({tag, ".done_pre"}, done, 0);
      tick();
      check({tag, ".done"},      done, 1);
      check({tag, ".idle_post"}, out_valid, 0);
   endtask

   task automatic do_reset();
      inst       = '0;
      snoop_we   = 1'b0;
      snoop_addr = '0;
      snoop_data = '0;
      out_ready  = 1'b1;
      reset      = 1'b1;
      @(posedge clock);
      #1;
      check("rst.valid",    out_valid, 0);
      check("rst.data",     out_data,  0);
      check("rst.mem_addr", mem_addr,  0);
      check("rst.done",     done,      0);
      check("rst.timeout",  timeout,   0);
      check("rst.overflow", overflow,  0);
      reset = 1'b0;
      cyc   = 1;
   endtask

   initial begin
      int ei;
      mem_model[0] = 32'd1;
      mem_model[1] = 32'd2;
      mem_model[2] = 32'd3;
      mem_model[3] = 32'd5;

      // A: traced store, out-of-window store, halt at cycle 10
      do_reset();
      check("a.idle", out_valid, 0);
      goto(3);
      snoop_we = 1'b1; snoop_addr = c_BASE + 32'd8; snoop_data = 32'h37;
      tick();
      snoop_we = 1'b0;
      expect_rec("a.trace", c_KIND_TRACE, 16'd2, 32'h37);
      tick();
      snoop_we = 1'b1; snoop_addr = c_BASE - 32'd4; snoop_data = 32'h99;
      tick();
      snoop_we = 1'b0;
      check("a.miss", out_valid, 0);
      goto(10);
      inst = c_HALT;
      tick();
      inst = '0;
      check("a.drain", out_valid, 0);
      tick();
      expect_dump("a");
      expect_summary("a", 16'd0, 32'd10);

      // B: six hits into a depth-4 FIFO with the sink stalled
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         goto(k);
         snoop_we = 1'b1; snoop_addr = c_BASE + 32'(4 * (k % 4)); snoop_data = 32'hA0 + 32'(k);
         if (k == 5) check("b.ovf_pre", overflow, 0);
         if (k == 6) check("b.ovf_set", overflow, 1);
      end
      tick();
      snoop_we = 1'b0;
      expect_rec("b.head", c_KIND_TRACE, 16'd1, 32'hA1);
      tick();
      inst = c_HALT;
      tick();
      inst = '0; out_ready = 1'b1;
      expect_rec("b.r1", c_KIND_TRACE, 16'd1, 32'hA1);
      tick();
      snoop_we = 1'b1; snoop_addr = c_BASE; snoop_data = 32'hEE;
      expect_rec("b.r2", c_KIND_TRACE, 16'd2, 32'hA2);
      tick();
      snoop_we = 1'b0;
      expect_rec("b.r3", c_KIND_TRACE, 16'd3, 32'hA3);
      tick();
      expect_rec("b.r4", c_KIND_TRACE, 16'd0, 32'hA4);
      tick();
      check("b.empty", out_valid, 0);
      tick();
      expect_dump("b");
      expect_summary("b", 16'd2, 32'd8);

      // D: push+pop at full, then run into the cycle timeout
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         goto(k);
         snoop_we = 1'b1; snoop_addr = c_BASE + 32'(4 * ((k - 1) % 4)); snoop_data = 32'hC0 + 32'(k);
         if (k == 5) begin
            out_ready = 1'b1;
            expect_rec("d.full_pp", c_KIND_TRACE, 16'd0, 32'hC1);
         end
      end
      tick();
      snoop_we = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         expect_rec($sformatf("d.r%0d", k), c_KIND_TRACE, 16'((k - 1) % 4), 32'hC0 + 32'(k));
         tick();
      end
      check("d.empty",  out_valid, 0);
      check("d.no_ovf", overflow,  0);
      goto(50);
      check("d.tmo_pre", timeout, 0);
      tick();
      check("d.tmo",   timeout,   1);
      check("d.drain", out_valid, 0);
      tick();
      expect_dump("d");
      expect_summary("d", 16'd1, 32'd50);

      // E: halt on the timeout cycle itself
      do_reset();
      goto(50);
      inst = c_HALT;
      tick();
      inst = '0;
      check("e.no_tmo", timeout, 0);
      tick();
      expect_dump("e");
      expect_summary("e", 16'd0, 32'd50);

      // F: out_ready toggling every cycle during the dump
      do_reset();
      goto(2);
      inst = c_HALT;
      tick();
      inst = '0;
      tick();
      ei = 0;
      for (int k = 0; k < 16 && ei < NUM_WORDS; k++) begin
         out_ready = (cyc % 2 == 1);
         expect_rec($sformatf("f.c%0d", cyc), c_KIND_DUMP, 16'(ei), mem_model[ei]);
         if (out_ready) ei++;
         tick();
      end
      out_ready = 1'b1;
      expect_summary("f", 16'd0, 32'd2);

      // G: asynchronous reset in the middle of the dump
      do_reset();
      goto(2);
      inst = c_HALT;
      tick();
      inst = '0;
      goto(6);
      expect_rec("g.pre", c_KIND_DUMP, 16'd2, 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check("g.async.valid",    out_valid, 0);
      check("g.async.kind",     out_kind,  0);
      check("g.async.index",    out_index, 0);
      check("g.async.data",     out_data,  0);
      check("g.async.mem_addr", mem_addr,  0);
      check("g.async.done",     done,      0);
      do_reset();
      check("g.done_clr", done, 0);
      goto(3);
      inst = c_HALT;
      tick();
      inst = '0;
      tick();
      expect_dump("g");
      expect_summary("g", 16'd0, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
